regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised successor to the single-port regfile: DEPTH x WIDTH register file with two
//  registered read ports, one write port, write-to-read bypass, optional hardwired-zero
//  register 0 and a per-register pending scoreboard. Sits between decode (reads, pending set)
//  and writeback (write, pending clear) in the xCPU pipeline.
// PARAMETERS
//  WIDTH     32  data width in bits
//  DEPTH     32  number of registers, power of two, >= 2
//  AW        5   address width, must equal $clog2(DEPTH)
//  ZERO_REG  1   1: reg 0 reads 0, ignores writes, never pending; 0: reg 0 is ordinary
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  ra_en     in   1      read port A enable
//  ra_addr   in   AW     read port A address
//  ra_data   out  WIDTH  read port A data, valid 1 cycle after ra_en
//  ra_pend   out  1      pending bit of ra_addr, captured with ra_data
//  rb_en     in   1      read port B enable
//  rb_addr   in   AW     read port B address
//  rb_data   out  WIDTH  read port B data, valid 1 cycle after rb_en
//  rb_pend   out  1      pending bit of rb_addr, captured with rb_data
//  we        in   1      write enable
//  w_addr    in   AW     write address
//  w_data    in   WIDTH  write data
//  ps_en     in   1      pending-set enable (decode issued an instruction writing ps_addr)
//  ps_addr   in   AW     register to mark pending
//  pend_vec  out  DEPTH  current pending bits, combinational from state
// BEHAVIOUR
//  - Reset (async, any time incl. mid-write): all registers = 0, pending = 0, ra_data/rb_data = 0,
//    ra_pend/rb_pend = 0. Cycle in which reset is asserted performs no write, no pending set.
//  - Write: we=1 at edge -> mem[w_addr] <= w_data; pending[w_addr] <= 0.
//  - Read: rX_en=1 at edge -> rX_data <= value of mem[rX_addr], rX_pend <= pending[rX_addr];
//    rX_en=0 -> rX_data/rX_pend hold previous values. Latency exactly 1 cycle.
//  - Bypass: rX_en & we & rX_addr==w_addr in the same cycle -> rX_data <= w_data, rX_pend <= 0
//    (write-first). Both ports may bypass simultaneously; ports A and B are independent.
//  - Pending set: ps_en=1 -> pending[ps_addr] <= 1. If we & w_addr==ps_addr same cycle, set wins
//    (new producer issued after old one retires): pending stays 1, mem still written.
//  - Read coincident with ps_en on same addr returns pending bit BEFORE the set (0 if clear).
//  - ZERO_REG=1: reads of addr 0 return 0 and pend 0; writes and ps_en to addr 0 ignored;
//    bypass never applies to addr 0; pending[0] constant 0.
//  - Addresses are AW bits; DEPTH==2**AW, so no out-of-range case exists.
// STRUCTURE
//  - Shared header regfile.h: `ENABLE/`DISABLE, default `DATA_W, `DATA_D, `ADDR_W used as
//    parameter defaults; no other constants.
//  - One sub-module regfile_read_port (instantiated twice): address decode, bypass compare,
//    zero-reg mux, output/pending registers. Storage array, pending vector in top.
// TESTING
//  1 Reset: assert reset mid-run after writing 0xDEAD to r5 -> outputs 0; read r5 next -> 0.
//  2 Write/read sweep: write r[i]=i*3+1 for all i, read each on A and B -> data after 1 cycle;
//    r0 reads 0 with ZERO_REG=1, reads 1 with ZERO_REG=0.
//  3 Bypass: r7=0x11; same cycle we r7=0x22 & ra_en r7 & rb_en r7 -> both ports 0x22, pend 0.
//  4 Scoreboard: ps_en r9 -> pend_vec[9]=1, read r9 gives pend 1; we r9=0x5 -> pend 0, data 5;
//    ps_en r9 and we r9 same cycle -> pend_vec[9] stays 1.
//  5 Hold: ra_en=0 for 3 cycles while r3 rewritten -> ra_data unchanged from last read.
//  6 Zero reg: we r0=0xFFFF, ps_en r0 -> reads 0, pend_vec[0]=0 (ZERO_REG=1).

Source files
------------

// File: rtl/regfile_2r1w_pkg.sv
// Shared defaults for the 2-read/1-write register file and its interface.
package regfile_2r1w_pkg;
  localparam int DATA_W = 32;
  localparam int DATA_D = 32;
  localparam int ADDR_W = 5;
  localparam bit ENABLE = 1'b1;
endpackage

// File: rtl/regfile_2r1w_if.sv
// Decode/writeback side of the register file: two read ports, write port, pending set.
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DATA_D,
  parameter int AW    = ADDR_W
) ();
  logic             ra_en;
  logic [AW-1:0]    ra_addr;
  logic [WIDTH-1:0] ra_data;
  logic             ra_pend;
  logic             rb_en;
  logic [AW-1:0]    rb_addr;
  logic [WIDTH-1:0] rb_data;
  logic             rb_pend;
  logic             we;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_data;
  logic             ps_en;
  logic [AW-1:0]    ps_addr;
  logic [DEPTH-1:0] pend_vec;

  modport master (
    output ra_en, ra_addr, rb_en, rb_addr, we, w_addr, w_data, ps_en, ps_addr,
    input  ra_data, ra_pend, rb_data, rb_pend, pend_vec
  );

  modport slave (
    input  ra_en, ra_addr, rb_en, rb_addr, we, w_addr, w_data, ps_en, ps_addr,
    output ra_data, ra_pend, rb_data, rb_pend, pend_vec
  );
endinterface

// File: rtl/regfile_2r1w_read_port.sv
// One registered read port: array select, write-first bypass, zero-register mux.
module regfile_2r1w_read_port
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int DEPTH    = DATA_D,
  parameter int AW       = ADDR_W,
  parameter bit ZERO_REG = ENABLE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [AW-1:0]                addr,
  input  logic                         we,
  input  logic [AW-1:0]                w_addr,
  input  logic [WIDTH-1:0]             w_data,
  input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
  input  logic [DEPTH-1:0]             pending,
  output logic [WIDTH-1:0]             data,
  output logic                         pend
);
  logic             is_zero;
  logic             hit;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_pend;

  assign is_zero = ZERO_REG && (addr == '0);
  assign hit     = we && (w_addr == addr);

  // Pending is sampled before any same-cycle set; a retiring write clears it.
  always_comb begin
    nxt_data = mem[addr];
    nxt_pend = pending[addr];
    if (is_zero) begin
      nxt_data = '0;
      nxt_pend = 1'b0;
    end else if (hit) begin
      nxt_data = w_data;
      nxt_pend = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      pend <= 1'b0;
    end else if (en) begin
      data <= nxt_data;
      pend <= nxt_pend;
    end
  end
endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register file, two registered read ports with bypass, pending scoreboard.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH    = DATA_W,
  parameter int DEPTH    = DATA_D,
  parameter int AW       = ADDR_W,
  parameter bit ZERO_REG = ENABLE
) (
  input  logic          clk,
  input  logic          reset,
  regfile_2r1w_if.slave rf
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            pending;
  logic                        wr_ok;
  logic                        ps_ok;

  assign wr_ok = rf.we    && !(ZERO_REG && (rf.w_addr  == '0));
  assign ps_ok = rf.ps_en && !(ZERO_REG && (rf.ps_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[rf.w_addr] <= rf.w_data;
    end
  end

  // Set is applied after clear so a new producer on the retiring register wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      if (wr_ok) pending[rf.w_addr]  <= 1'b0;
      if (ps_ok) pending[rf.ps_addr] <= 1'b1;
    end
  end

  assign rf.pend_vec = pending;

  regfile_2r1w_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_port_a (
    .clk(clk), .reset(reset), .en(rf.ra_en), .addr(rf.ra_addr),
    .we(rf.we), .w_addr(rf.w_addr), .w_data(rf.w_data),
    .mem(mem), .pending(pending), .data(rf.ra_data), .pend(rf.ra_pend)
  );

  regfile_2r1w_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)
  ) u_port_b (
    .clk(clk), .reset(reset), .en(rf.rb_en), .addr(rf.rb_addr),
    .we(rf.we), .w_addr(rf.w_addr), .w_data(rf.w_data),
    .mem(mem), .pending(pending), .data(rf.rb_data), .pend(rf.rb_pend)
  );
endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench: dut0 has ZERO_REG=1, dut1 has ZERO_REG=0 (reads enabled only in the sweep).
module tb_regfile_2r1w;
  import regfile_2r1w_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ra_en, rb_en, we, ps_en, dut1_on;
  logic [4:0]  ra_addr, rb_addr, w_addr, ps_addr;
  logic [31:0] w_data;

  int n_total = 0;
  int n_pass  = 0;

  exp_t  exp_q[4][$];
  logic [3:0] fire;
  string nm[4] = '{"dut0_a", "dut0_b", "dut1_a", "dut1_b"};

  regfile_2r1w_if bus0 ();
  regfile_2r1w_if bus1 ();

  assign bus0.ra_en = ra_en;            assign bus1.ra_en = ra_en & dut1_on;
  assign bus0.rb_en = rb_en;            assign bus1.rb_en = rb_en & dut1_on;
  assign bus0.ra_addr = ra_addr;        assign bus1.ra_addr = ra_addr;
  assign bus0.rb_addr = rb_addr;        assign bus1.rb_addr = rb_addr;
  assign bus0.we = we;                  assign bus1.we = we;
  assign bus0.w_addr = w_addr;          assign bus1.w_addr = w_addr;
  assign bus0.w_data = w_data;          assign bus1.w_data = w_data;
  assign bus0.ps_en = ps_en;            assign bus1.ps_en = ps_en;
  assign bus0.ps_addr = ps_addr;        assign bus1.ps_addr = ps_addr;

  regfile_2r1w #(.ZERO_REG(1'b1)) dut0 (.clk(clk), .reset(reset), .rf(bus0));
  regfile_2r1w #(.ZERO_REG(1'b0)) dut1 (.clk(clk), .reset(reset), .rf(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a read accepted at a rising edge is compared at the following falling edge.
  always @(posedge clk) fire <= {bus1.rb_en, bus1.ra_en, bus0.rb_en, bus0.ra_en};

  always @(negedge clk) begin
    logic [32:0] act;
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (fire[p]) begin
        case (p)
          0: act = {bus0.ra_pend, bus0.ra_data};
          1: act = {bus0.rb_pend, bus0.rb_data};
          2: act = {bus1.ra_pend, bus1.ra_data};
          default: act = {bus1.rb_pend, bus1.rb_data};
        endcase
        if (exp_q[p].size() == 0) begin
          n_total++;
          $display("FAIL %s_unexpected: got %0h expected no output", nm[p], act);
        end else begin
          e = exp_q[p].pop_front();
          check(nm[p], {31'd0, act}, {31'd0, e.pend, e.data});
        end
      end
    end
  end

  task automatic clr();
    ra_en = 0; rb_en = 0; we = 0; ps_en = 0;
    ra_addr = 0; rb_addr = 0; w_addr = 0; ps_addr = 0; w_data = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    clr();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1; w_addr = a[4:0]; w_data = d;
  endtask

  task automatic ps(input int a);
    ps_en = 1; ps_addr = a[4:0];
  endtask

  task automatic push(input int p, input logic [31:0] d, input logic pn);
    exp_t e;
    e.data = d;
    e.pend = pn;
    exp_q[p].push_back(e);
  endtask

  task automatic rda(input int a, input logic [31:0] d, input logic pn);
    ra_en = 1; ra_addr = a[4:0]; push(0, d, pn);
  endtask

  task automatic rdb(input int a, input logic [31:0] d, input logic pn);
    rb_en = 1; rb_addr = a[4:0]; push(1, d, pn);
  endtask

  initial begin
    int qleft;
    clr();
    dut1_on = 0;
    reset = 1;
    #12;
    check("rst_ra_data", {32'd0, bus0.ra_data}, 64'd0);
    check("rst_pend_vec", {32'd0, bus0.pend_vec}, 64'd0);
    @(negedge clk);
    reset = 0;

    // reset mid-run, with a write and a pending bit in flight
    ps(12); wr(5, 32'hDEAD); tick();
    rda(5, 32'hDEAD, 0); tick();
    check("pend12_set", {63'd0, bus0.pend_vec[12]}, 64'd1);
    wr(5, 32'hBEEF); ps(13);
    #2 reset = 1;
    #1;
    check("rst_mid_ra", {31'd0, bus0.ra_pend, bus0.ra_data}, 64'd0);
    check("rst_mid_rb", {31'd0, bus0.rb_pend, bus0.rb_data}, 64'd0);
    check("rst_mid_pend", {32'd0, bus0.pend_vec}, 64'd0);
    @(negedge clk);
    clr();
    reset = 0;
    rda(5, 0, 0); rdb(5, 0, 0); tick();
    check("rst_no_pend13", {32'd0, bus0.pend_vec}, 64'd0);

    // write/read sweep; r0 differs between the two instances
    for (int i = 0; i < 32; i++) begin
      wr(i, i * 3 + 1); tick();
    end
    dut1_on = 1;
    for (int i = 0; i < 32; i++) begin
      rda(i, (i == 0) ? 32'd0 : i * 3 + 1, 0);
      rdb(i, (i == 0) ? 32'd0 : i * 3 + 1, 0);
      push(2, i * 3 + 1, 0);
      push(3, i * 3 + 1, 0);
      tick();
    end
    tick();
    dut1_on = 0;

    // bypass on both ports at once
    wr(7, 32'h11); tick();
    wr(7, 32'h22); rda(7, 32'h22, 0); rdb(7, 32'h22, 0); tick();
    rda(7, 32'h22, 0); tick();

    // pending scoreboard
    ps(9); tick();
    check("pend9_set", {63'd0, bus0.pend_vec[9]}, 64'd1);
    rda(9, 28, 1); tick();
    wr(9, 5); tick();
    check("pend9_clr", {63'd0, bus0.pend_vec[9]}, 64'd0);
    rda(9, 5, 0); tick();
    ps(9); wr(9, 6); tick();
    check("pend9_set_wins", {63'd0, bus0.pend_vec[9]}, 64'd1);
    rdb(9, 6, 1); tick();
    ps(10); rda(10, 31, 0); tick();
    check("pend10_set", {63'd0, bus0.pend_vec[10]}, 64'd1);
    rda(10, 31, 1); tick();

    // hold while disabled
    rda(3, 10, 0); tick();
    for (int k = 0; k < 3; k++) begin
      wr(3, 32'h77 + k); tick();
      check("hold_ra", {31'd0, bus0.ra_pend, bus0.ra_data}, 64'd10);
    end
    rda(3, 32'h79, 0); tick();

    // hardwired zero register
    wr(0, 32'hFFFF); ps(0); tick();
    check("zero_pend", {63'd0, bus0.pend_vec[0]}, 64'd0);
    rda(0, 0, 0); rdb(0, 0, 0); tick();
    wr(0, 32'h1234); rda(0, 0, 0); tick();
    tick();
    tick();

    qleft = 0;
    for (int p = 0; p < 4; p++) qleft += exp_q[p].size();
    check("queue_drain", 64'(qleft), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
